// File: rtl/alu_arbiter.sv
// Round-robin front end for one shared 32-bit combinational ALU.
// One transaction in flight: grant, drive the ALU, then hold a registered response.
module alu_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*32-1:0]   req_a,
    input  logic [N_REQ*32-1:0]   req_b,
    input  logic [N_REQ*4-1:0]    req_op,
    output logic [31:0]           alu_port_a,
    output logic [31:0]           alu_port_b,
    output logic [3:0]            alu_opcode,
    input  logic [31:0]           alu_out,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [31:0]           resp_data,
    output logic                  resp_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [ID_W-1:0] last_grant_q, last_grant_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic [3:0]      op_q, op_d;
    logic            resp_valid_q, resp_valid_d;
    logic [ID_W-1:0] resp_id_q, resp_id_d;
    logic [31:0]     resp_data_q, resp_data_d;
    logic            resp_err_q, resp_err_d;

    logic            win_found;
    logic [ID_W-1:0] win_idx;
    int              idx;

    // Scan starts one past the previous winner so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_grant_q) + k) % N_REQ;
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (n_rst && state_q == IDLE && win_found) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    a_d          = req_a[32*win_idx +: 32];
                    b_d          = req_b[32*win_idx +: 32];
                    op_d         = req_op[4*win_idx +: 4];
                    id_d         = win_idx;
                    last_grant_d = win_idx;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                resp_data_d  = alu_out;
                resp_err_d   = (op_q > 4'd9);
                resp_id_d    = id_q;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(N_REQ - 1);
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign alu_port_a = a_q;
    assign alu_port_b = b_q;
    assign alu_opcode = op_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

endmodule
